// File: rtl/spi_reg_seq.sv
// spi_reg_seq: single-register read/write sequencer driving an SPI master one datagram at a time
module spi_reg_seq #(
    parameter int SIZE       = 40,
    parameter int ADDR_SIZE  = 7,
    parameter int DATA_SIZE  = 32,
    parameter int CS_SIZE    = 1,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 req_in,
    input  logic                 write_in,
    input  logic [ADDR_SIZE-1:0] addr_in,
    input  logic [DATA_SIZE-1:0] wdata_in,
    input  logic [CS_SIZE-1:0]   cs_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 error_out,
    output logic [DATA_SIZE-1:0] rdata_out,
    output logic [7:0]           status_out,
    output logic [SIZE-1:0]      spi_data_out,
    output logic                 spi_send_enable_out,
    output logic [CS_SIZE-1:0]   spi_cs_select_out,
    input  logic [SIZE-1:0]      spi_data_in,
    input  logic                 spi_send_n_in
);
    typedef enum logic [2:0] {IDLE, START, FRAME, GAP, DONE} state_t;
    localparam int CW = $clog2((TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES) + 1);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SIZE-1:0]     data_q, data_d;
    logic [CS_SIZE-1:0]  cs_q, cs_d;
    logic                pass_q, pass_d;
    logic                err_q, err_d;
    logic [DATA_SIZE-1:0] rdata_q, rdata_d;
    logic [7:0]          status_q, status_d;
    logic [2:0]          sync_q;
    logic                fall, rise, tmo;

    assign fall = !sync_q[1] && sync_q[2];
    assign rise = sync_q[1] && !sync_q[2];
    assign tmo  = cnt_q == CW'(TIMEOUT - 1);

    assign busy_out            = state_q != IDLE && state_q != DONE;
    assign done_out            = state_q == DONE;
    assign error_out           = err_q;
    assign rdata_out           = rdata_q;
    assign status_out          = status_q;
    assign spi_data_out        = data_q;
    assign spi_cs_select_out   = cs_q;
    assign spi_send_enable_out = state_q == START || state_q == FRAME;

    // two-flop synchronizer on the master's chip-select plus one history flop for edge detection; idles high
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) sync_q <= 3'b111;
        else sync_q <= {sync_q[1:0], spi_send_n_in};
    end

    // state and datapath registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            cs_q     <= '0;
            pass_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            cs_q     <= cs_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
        end
    end

    // next-state: accept, frame start/end tracking with timeout, fixed gap, second pass for reads
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        data_d   = data_q;
        cs_d     = cs_q;
        pass_d   = pass_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_in) begin
                    data_d  = {write_in, addr_in, write_in ? wdata_in : {DATA_SIZE{1'b0}}};
                    cs_d    = cs_in;
                    err_d   = 1'b0;
                    pass_d  = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (fall) begin
                    state_d = FRAME;
                    cnt_d   = '0;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            FRAME: begin
                if (rise) begin
                    rdata_d  = spi_data_in[DATA_SIZE-1:0];
                    status_d = spi_data_in[SIZE-1 -: 8];
                    state_d  = GAP;
                    cnt_d    = '0;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = (!err_q && !data_q[SIZE-1] && !pass_q) ? START : DONE;
                    pass_d  = 1'b1;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_reg_seq.sv
// tb_spi_reg_seq: scoreboard bench for spi_reg_seq with a behavioural SPI master attached
module tb_spi_reg_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [6:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        cs = 1'b0;
    logic        busy, done, err, en;
    logic [31:0] rdata;
    logic [7:0]  status;
    logic [39:0] spi_tx;
    logic [0:0]  spi_cs;
    logic [39:0] spi_rx = '0;
    logic        spi_send_n = 1'b1;
    logic        hang = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [40:0] exp_q[$];
    logic [40:0] exp_dg_q[$];
    logic [39:0] resp_q[$];

    spi_reg_seq #(.TIMEOUT(64)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .req_in(req), .write_in(wr), .addr_in(addr),
        .wdata_in(wdata), .cs_in(cs), .busy_out(busy), .done_out(done), .error_out(err),
        .rdata_out(rdata), .status_out(status), .spi_data_out(spi_tx),
        .spi_send_enable_out(en), .spi_cs_select_out(spi_cs), .spi_data_in(spi_rx),
        .spi_send_n_in(spi_send_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event occurred with nothing expected", name);
    endtask

    // behavioural master: on enable, drop CS, shift 40 bits, present response, raise CS, wait for enable low
    initial begin
        bit aborted;
        forever begin
            @(negedge clk);
            if (!en || hang) continue;
            repeat (2) @(negedge clk);
            if (!en) continue;
            spi_send_n = 1'b0;
            aborted = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (!en) begin
                    aborted = 1'b1;
                    break;
                end
            end
            if (aborted) begin
                spi_send_n = 1'b1;
                continue;
            end
            if (exp_dg_q.size() == 0) fail_now("datagram_extra");
            else chk("datagram", {23'd0, spi_cs, spi_tx}, {23'd0, exp_dg_q.pop_front()});
            spi_rx = resp_q.size() != 0 ? resp_q.pop_front() : 40'd0;
            spi_send_n = 1'b1;
            for (int i = 0; i < 200 && en; i++) @(negedge clk);
        end
    end

    // completion monitor: each done pulse is matched against the oldest expected response
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) fail_now("done_extra");
            else chk("done_resp", {23'd0, err, status, rdata}, {23'd0, exp_q.pop_front()});
        end
    end

    // inter-frame gap monitor: length of each enable-low run that ends in a new frame while busy
    logic prev_en = 1'b0;
    logic counting = 1'b0;
    int   gcnt = 0;
    always @(negedge clk) begin
        if (!busy) begin
            counting <= 1'b0;
            gcnt <= 0;
        end else if (!en) begin
            if (prev_en || counting) begin
                counting <= 1'b1;
                gcnt <= prev_en ? 1 : gcnt + 1;
            end
        end else if (counting) begin
            chk("gap_len", 64'(gcnt), 64'd16);
            counting <= 1'b0;
        end
        prev_en <= en;
    end

    task automatic issue(input logic w, input logic [6:0] a, input logic [31:0] d, input logic c);
        @(negedge clk);
        wr = w;
        addr = a;
        wdata = d;
        cs = c;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("wait_done_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_en", 64'(en), 0);
        chk("rst_tx", 64'(spi_tx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single write frame
        exp_dg_q.push_back({1'b0, 40'hEC000100C3});
        resp_q.push_back(40'h0FCAFEF00D);
        exp_q.push_back({1'b0, 8'h0F, 32'hCAFEF00D});
        issue(1'b1, 7'h6C, 32'h000100C3, 1'b0);
        wait_done();

        // read: two identical frames, second frame's response is the result
        exp_dg_q.push_back({1'b0, 40'h6F00000000});
        exp_dg_q.push_back({1'b0, 40'h6F00000000});
        resp_q.push_back(40'h0011111111);
        resp_q.push_back(40'h0512345678);
        exp_q.push_back({1'b0, 8'h05, 32'h12345678});
        issue(1'b0, 7'h6F, 32'hFFFFFFFF, 1'b0);
        wait_done();

        // no frame ever starts: enable held for TIMEOUT cycles, error set, last capture kept
        hang = 1'b1;
        exp_q.push_back({1'b1, 8'h05, 32'h12345678});
        issue(1'b1, 7'h01, 32'h0, 1'b0);
        n = 0;
        for (int i = 0; i < 200 && !en; i++) @(negedge clk);
        while (en && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_en_cycles", 64'(n), 64'd64);
        wait_done();
        hang = 1'b0;

        // request while busy and address change mid-frame are both ignored
        exp_dg_q.push_back({1'b0, 40'h90A5A5A5A5});
        resp_q.push_back(40'h7700000001);
        exp_q.push_back({1'b0, 8'h77, 32'h00000001});
        issue(1'b1, 7'h10, 32'hA5A5A5A5, 1'b0);
        for (int i = 0; i < 200 && spi_send_n; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        req = 1'b1;
        wr = 1'b0;
        addr = 7'h55;
        @(negedge clk);
        req = 1'b0;
        addr = 7'h7F;
        wdata = 32'h0;
        wait_done();

        // asynchronous reset in the middle of a frame
        exp_dg_q.push_back({1'b0, 40'hA200000001});
        exp_q.push_back({1'b0, 8'h00, 32'h0});
        issue(1'b1, 7'h22, 32'h00000001, 1'b1);
        for (int i = 0; i < 200 && spi_send_n; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 64'(en), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_rdata", 64'(rdata), 0);
        chk("mid_rst_status", 64'(status), 0);
        chk("mid_rst_tx", 64'(spi_tx), 0);
        chk("mid_rst_cs", 64'(spi_cs), 0);
        exp_q.delete();
        exp_dg_q.delete();
        resp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // normal operation after reset, nonzero device select
        exp_dg_q.push_back({1'b1, 40'hEC000100C3});
        resp_q.push_back(40'h3300000042);
        exp_q.push_back({1'b0, 8'h33, 32'h00000042});
        issue(1'b1, 7'h6C, 32'h000100C3, 1'b1);
        wait_done();

        repeat (50) @(negedge clk);
        chk("sb_done_left", 64'(exp_q.size()), 0);
        chk("sb_frames_left", 64'(exp_dg_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
